// File: rtl/missile_ctl_if.sv
// Signal bundle between the missile sequencer and its surroundings.
// The controller is the slave. The bench or ship logic is the master.
interface missile_ctl_if;
    logic        vblnk_in;
    logic        fire;
    logic        hit;
    logic [10:0] ship_x;
    logic [10:0] ship_y;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        on;
    logic        shot_fired;
    logic        busy;

    modport master (
        output vblnk_in, fire, hit, ship_x, ship_y,
        input  xpos, ypos, on, shot_fired, busy
    );

    modport slave (
        input  vblnk_in, fire, hit, ship_x, ship_y,
        output xpos, ypos, on, shot_fired, busy
    );
endinterface

// File: rtl/missile_ctl.sv
// Single-missile sequencer: launch from the ship on a fire edge, then rise once per frame.
// The missile retires on a hit or at the top of the screen, then waits out a frame cooldown.
module missile_ctl #(
    parameter int SPEED       = 4,
    parameter int MISSILE_H   = 20,
    parameter int COOLDOWN_FR = 8
) (
    input  logic         pclk,
    input  logic         rst,
    missile_ctl_if.slave bus
);
    localparam logic [10:0] SPEED_W  = 11'(SPEED);
    localparam logic [10:0] HEIGHT_W = 11'(MISSILE_H);
    localparam logic [7:0]  CD_INIT  = 8'(COOLDOWN_FR);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [10:0] xpos, xpos_nxt;
    logic [10:0] ypos, ypos_nxt;
    logic        on, on_nxt;
    logic        shot_fired, shot_fired_nxt;
    logic        busy;
    logic        fire_d, vblnk_d;
    logic        fire_rise, tick, launch_ok, top_exit;

    assign fire_rise = bus.fire & ~fire_d;
    assign tick      = bus.vblnk_in & ~vblnk_d;
    assign launch_ok = fire_rise && (bus.ship_y >= HEIGHT_W);
    // Compare before subtracting so ypos can never wrap past zero.
    assign top_exit  = tick && (ypos < SPEED_W);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            xpos       <= 11'd0;
            ypos       <= 11'd0;
            on         <= 1'b0;
            shot_fired <= 1'b0;
            busy       <= 1'b0;
            fire_d     <= 1'b0;
            vblnk_d    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            xpos       <= xpos_nxt;
            ypos       <= ypos_nxt;
            on         <= on_nxt;
            shot_fired <= shot_fired_nxt;
            busy       <= (state_nxt != IDLE);
            fire_d     <= bus.fire;
            vblnk_d    <= bus.vblnk_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (launch_ok) state_nxt = FLY;
            FLY:      if (bus.hit || top_exit) state_nxt = COOLDOWN;
            COOLDOWN: if (tick && cnt == 8'd1) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt        = cnt;
        xpos_nxt       = xpos;
        ypos_nxt       = ypos;
        on_nxt         = on;
        shot_fired_nxt = 1'b0;
        case (state)
            IDLE: begin
                on_nxt = 1'b0;
                if (launch_ok) begin
                    xpos_nxt       = bus.ship_x;
                    ypos_nxt       = bus.ship_y - HEIGHT_W;
                    on_nxt         = 1'b1;
                    shot_fired_nxt = 1'b1;
                end
            end
            FLY: begin
                // A hit outranks a frame tick arriving in the same cycle.
                if (bus.hit || top_exit) begin
                    on_nxt  = 1'b0;
                    cnt_nxt = CD_INIT;
                end else if (tick) begin
                    ypos_nxt = ypos - SPEED_W;
                end
            end
            COOLDOWN: begin
                on_nxt = 1'b0;
                if (tick) cnt_nxt = cnt - 8'd1;
            end
            default: on_nxt = 1'b0;
        endcase
    end

    assign bus.xpos       = xpos;
    assign bus.ypos       = ypos;
    assign bus.on         = on;
    assign bus.shot_fired = shot_fired;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_missile_ctl.sv
// Directed bench for missile_ctl: reset, launch/flight, top exit, hit, ignore and reject.
module tb_missile_ctl;
    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    missile_ctl_if bus ();

    missile_ctl dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    // Observed vector layout: {on, busy, shot_fired, xpos, ypos}
    function automatic logic [34:0] obs();
        return {bus.on, bus.busy, bus.shot_fired, bus.xpos, bus.ypos};
    endfunction

    function automatic logic [34:0] exp_v(logic o, logic b, logic s, int x, int y);
        return {o, b, s, 11'(x), 11'(y)};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic frame();
        bus.vblnk_in = 1'b1;
        step();
        bus.vblnk_in = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.fire     = 1'b0;
        bus.hit      = 1'b0;
        bus.vblnk_in = 1'b0;
        step(2);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [34:0] e;
        bus.ship_x   = 11'd300;
        bus.ship_y   = 11'd560;
        bus.hit      = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.fire     = 1'b1;
        rst          = 1'b1;
        step(3);
        e = exp_v(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", obs(), e);
        end
        rst = 1'b0;
        step();
        e = exp_v(1, 1, 1, 300, 540);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_release_launch: got %h want %h", obs(), e);
        end
        step(3);
        e = exp_v(1, 1, 0, 300, 540);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL held_fire_single_shot: got %h want %h", obs(), e);
        end
        bus.fire = 1'b0;
        rst = 1'b1;
        step();
        e = exp_v(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reset_midflight: got %h want %h", obs(), e);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_launch_flight();
        logic [34:0] e;
        do_reset();
        bus.ship_x   = 11'd300;
        bus.ship_y   = 11'd560;
        bus.fire     = 1'b1;
        bus.vblnk_in = 1'b1;
        step();
        e = exp_v(1, 1, 1, 300, 540);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL launch: got %h want %h", obs(), e);
        end
        bus.fire     = 1'b0;
        bus.vblnk_in = 1'b0;
        step();
        e = exp_v(1, 1, 0, 300, 540);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL launch_tick_no_move: got %h want %h", obs(), e);
        end
        repeat (3) frame();
        e = exp_v(1, 1, 0, 300, 528);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL three_ticks: got %h want %h", obs(), e);
        end
        bus.ship_x = 11'd50;
        frame();
        e = exp_v(1, 1, 0, 300, 524);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL ship_move_xpos_frozen: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_top_exit();
        logic [34:0] e;
        int shots;
        do_reset();
        bus.ship_x = 11'd100;
        bus.ship_y = 11'd26;
        bus.fire   = 1'b1;
        step();
        bus.fire = 1'b0;
        step();
        // Fire presses while flying must not produce a shot.
        shots = 0;
        repeat (3) begin
            bus.fire = 1'b1;
            step();
            shots += int'(bus.shot_fired);
            bus.fire = 1'b0;
            step();
            shots += int'(bus.shot_fired);
        end
        n_cmp++;
        if (shots !== 0) begin
            n_bad++;
            $display("FAIL fire_ignored_in_fly: got %0d want 0", shots);
        end
        frame();
        e = exp_v(1, 1, 0, 100, 2);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL top_step_to_2: got %h want %h", obs(), e);
        end
        frame();
        e = exp_v(0, 1, 0, 100, 2);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL top_exit_retire: got %h want %h", obs(), e);
        end
        repeat (7) frame();
        e = exp_v(0, 1, 0, 100, 2);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL cooldown_7_ticks: got %h want %h", obs(), e);
        end
        frame();
        e = exp_v(0, 0, 0, 100, 2);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL cooldown_done: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_hit();
        logic [34:0] e;
        int shots;
        do_reset();
        bus.ship_x = 11'd200;
        bus.ship_y = 11'd420;
        bus.fire   = 1'b1;
        step();
        bus.fire = 1'b0;
        step();
        bus.hit      = 1'b1;
        bus.vblnk_in = 1'b1;
        step();
        e = exp_v(0, 1, 0, 200, 400);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL hit_beats_tick: got %h want %h", obs(), e);
        end
        bus.hit      = 1'b0;
        bus.vblnk_in = 1'b0;
        step();
        shots = 0;
        repeat (3) begin
            bus.fire = 1'b1;
            step();
            shots += int'(bus.shot_fired);
            bus.fire = 1'b0;
            step();
            shots += int'(bus.shot_fired);
        end
        n_cmp++;
        if (shots !== 0) begin
            n_bad++;
            $display("FAIL fire_ignored_in_cooldown: got %0d want 0", shots);
        end
        repeat (7) frame();
        // Button held across the return to IDLE must not launch.
        bus.fire = 1'b1;
        step();
        frame();
        step(3);
        e = exp_v(0, 0, 0, 200, 400);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL held_fire_no_relaunch: got %h want %h", obs(), e);
        end
        bus.fire = 1'b0;
        step();
        bus.fire = 1'b1;
        step();
        e = exp_v(1, 1, 1, 200, 400);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL new_edge_relaunch: got %h want %h", obs(), e);
        end
        bus.fire = 1'b0;
        step();
    endtask

    task automatic test_reject();
        logic [34:0] e;
        do_reset();
        bus.ship_x = 11'd77;
        bus.ship_y = 11'd10;
        bus.fire   = 1'b1;
        step();
        e = exp_v(0, 0, 0, 0, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL reject_low_ship: got %h want %h", obs(), e);
        end
        bus.fire = 1'b0;
        step();
        bus.ship_y = 11'd20;
        bus.fire   = 1'b1;
        step();
        e = exp_v(1, 1, 1, 77, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL launch_at_boundary: got %h want %h", obs(), e);
        end
        bus.fire = 1'b0;
        frame();
        e = exp_v(0, 1, 0, 77, 0);
        n_cmp++;
        if (obs() !== e) begin
            n_bad++;
            $display("FAIL no_underflow_wrap: got %h want %h", obs(), e);
        end
    endtask

    initial begin
        bus.fire     = 1'b0;
        bus.hit      = 1'b0;
        bus.vblnk_in = 1'b0;
        bus.ship_x   = 11'd0;
        bus.ship_y   = 11'd0;
        test_reset();
        test_launch_flight();
        test_top_exit();
        test_hit();
        test_reject();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
